// File: rtl/k_zg_grad_accum.sv
`default_nettype none
// =============================================================================
// Module   : k_zg_grad_accum
// Brief    : Sums alpha*K_ZG (Q16) per axis over num_pts points and hands the
//            3-axis gradient downstream with valid/ready. Issue-side valid/alpha
//            are re-timed by PIPE_LAT to meet the matching K_ZG samples.
//            Optional macro K_ZG_SAT_EN: clamp results to DATA_WIDTH, drive sat_flag.
// Revision : 1.0 - initial release
// =============================================================================
module k_zg_grad_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int PIPE_LAT   = 30,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_pts,
    input  logic                  in_valid,
    input  logic [31:0]           alpha,
    input  logic [DATA_WIDTH-1:0] K_ZGx,
    input  logic [DATA_WIDTH-1:0] K_ZGy,
    input  logic [DATA_WIDTH-1:0] K_ZGz,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] grad_x,
    output logic [DATA_WIDTH-1:0] grad_y,
    output logic [DATA_WIDTH-1:0] grad_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag
);

    localparam int c_prod_w = 32 + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PIPE_LAT-1:0]   r_dv;
    logic [31:0]           r_da [PIPE_LAT];
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_num;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_grad [3];
    logic [DATA_WIDTH-1:0] w_grad [3];
    logic [DATA_WIDTH-1:0] w_k    [3];
    logic                  w_d_valid;
    logic [31:0]           w_d_alpha;
    logic                  w_clear;
    logic                  w_acc_en;
    logic                  w_load;
    logic                  w_accept;

    assign w_k[0]    = K_ZGx;
    assign w_k[1]    = K_ZGy;
    assign w_k[2]    = K_ZGz;
    assign w_d_valid = r_dv[PIPE_LAT-1];
    assign w_d_alpha = r_da[PIPE_LAT-1];

    // Issue-side valid/alpha delay line, aligned with the K_ZG pipeline output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv <= '0;
            for (int i = 0; i < PIPE_LAT; i++) r_da[i] <= '0;
        end else begin
            r_dv    <= PIPE_LAT'({r_dv, in_valid});
            r_da[0] <= alpha;
            for (int i = 1; i < PIPE_LAT; i++) r_da[i] <= r_da[i-1];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_acc_en    = 1'b0;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = (num_pts == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_d_valid) begin
                    w_acc_en = 1'b1;
                    if ((r_count + CNT_WIDTH'(1)) == r_num) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle captures the result; out_valid follows a cycle later
                if (!r_out_valid) begin
                    w_load = 1'b1;
                end else if (out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_num       <= '0;
            r_out_valid <= 1'b0;
            for (int a = 0; a < 3; a++) r_grad[a] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_count <= '0;
                r_num   <= num_pts;
            end else if (w_acc_en) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (w_load) begin
                r_grad      <= w_grad;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef K_ZG_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_grad_max = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] c_grad_min = ~c_grad_max;
    logic [2:0] w_clip;
    logic       r_sat;
`endif

    for (genvar a = 0; a < 3; a++) begin : g_axis
        logic signed [c_prod_w-1:0]  w_prod;
        logic signed [ACC_WIDTH-1:0] w_term;
        logic signed [ACC_WIDTH-1:0] r_acc;

        // Arithmetic shift floors the Q32 product back to Q16
        assign w_prod = c_prod_w'($signed(w_d_alpha)) * c_prod_w'($signed(w_k[a]));
        assign w_term = ACC_WIDTH'(w_prod >>> 16);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_acc <= '0;
            else if (w_clear)  r_acc <= '0;
            else if (w_acc_en) r_acc <= r_acc + w_term;
        end

`ifdef K_ZG_SAT_EN
        logic w_hi;
        logic w_lo;
        assign w_hi      = (r_acc > c_grad_max);
        assign w_lo      = (r_acc < c_grad_min);
        assign w_clip[a] = w_hi | w_lo;
        assign w_grad[a] = w_hi ? DATA_WIDTH'(c_grad_max) :
                           (w_lo ? DATA_WIDTH'(c_grad_min) : DATA_WIDTH'(r_acc));
`else
        assign w_grad[a] = DATA_WIDTH'(r_acc);
`endif
    end

`ifdef K_ZG_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_sat <= 1'b0;
        else if (w_load) r_sat <= |w_clip;
    end
    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign grad_x    = r_grad[0];
    assign grad_y    = r_grad[1];
    assign grad_z    = r_grad[2];

endmodule
`default_nettype wire

// File: tb/tb_k_zg_grad_accum.sv
`default_nettype none
// Bench for k_zg_grad_accum: directed scenarios with literal expectations, then
// randomized jobs compared each cycle against a transaction-level model.
module tb_k_zg_grad_accum;
    localparam int DW = 32;
    localparam int AW = 48;
    localparam int L  = 30;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic [CW-1:0] num_pts   = '0;
    logic          in_valid  = 1'b0;
    logic [31:0]   alpha     = '0;
    logic [DW-1:0] kx        = '0;
    logic [DW-1:0] ky        = '0;
    logic [DW-1:0] kz        = '0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          sat_flag;
    logic [DW-1:0] gx;
    logic [DW-1:0] gy;
    logic [DW-1:0] gz;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: when out_valid/busy are due, and the old/new result values
    int            m_ov_at     = -1;
    int            m_busy_from = -1;
    logic [DW-1:0] m_prev [3];
    logic [DW-1:0] m_new  [3];
    logic          m_prev_sat  = 1'b0;
    logic          m_new_sat   = 1'b0;
    int            ov_seen     = -1;
    logic          last_ov     = 1'b0;
    int            g_last_issue;

    logic [31:0]   job_alpha [16];
    logic [DW-1:0] job_k     [16][3];
    logic [DW-1:0] ksx [int];
    logic [DW-1:0] ksy [int];
    logic [DW-1:0] ksz [int];

    logic          e_ov;
    logic          e_busy;
    logic          e_sat;
    logic [DW-1:0] e_g [3];

    k_zg_grad_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE_LAT(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pts(num_pts),
        .in_valid(in_valid), .alpha(alpha),
        .K_ZGx(kx), .K_ZGy(ky), .K_ZGz(kz),
        .busy(busy), .grad_x(gx), .grad_y(gy), .grad_z(gz),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // K_ZG pipeline stand-in: scheduled values PIPE_LAT after issue, garbage otherwise
    always @(posedge clk) begin
        #1;
        if (ksx.exists(cyc)) begin
            kx = ksx[cyc]; ky = ksy[cyc]; kz = ksz[cyc];
            ksx.delete(cyc); ksy.delete(cyc); ksz.delete(cyc);
        end else begin
            kx = $urandom; ky = $urandom; kz = $urandom;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint term(input logic [31:0] a, input logic [31:0] k);
        longint p;
        p = longint'($signed(a)) * longint'($signed(k));
        return p >>> 16;
    endfunction

    // {sat, grad} from a running sum, wrapped to the accumulator width
    function automatic logic [DW:0] model_out(input longint acc);
        longint w;
        w = (acc <<< 16) >>> 16;
`ifdef K_ZG_SAT_EN
        if (w > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (w < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
        return {1'b0, w[DW-1:0]};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 2))
            0:       return v;
            1:       return {{12{v[19]}}, v[19:0]};
            default: return v[0] ? 32'h0001_0000 : 32'hFFFF_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            e_ov   = (m_ov_at >= 0) && (cyc >= m_ov_at);
            e_busy = (m_busy_from >= 0) && (cyc >= m_busy_from);
            for (int a = 0; a < 3; a++) e_g[a] = e_ov ? m_new[a] : m_prev[a];
            e_sat  = e_ov ? m_new_sat : m_prev_sat;
            if (out_valid && !last_ov) ov_seen = cyc;
            last_ov = out_valid;
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("busy",      64'(busy),      64'(e_busy));
            chk("grad_x",    64'(gx),        64'(e_g[0]));
            chk("grad_y",    64'(gy),        64'(e_g[1]));
            chk("grad_z",    64'(gz),        64'(e_g[2]));
            chk("sat_flag",  64'(sat_flag),  64'(e_sat));
            if (e_ov && out_valid && out_ready) begin
                m_prev      = m_new;
                m_prev_sat  = m_new_sat;
                m_ov_at     = -1;
                m_busy_from = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit noise);
        tick();
        start     = noise && ($urandom_range(0, 3) == 0);
        num_pts   = CW'($urandom);
        out_ready = noise && ($urandom_range(0, 1) == 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        m_ov_at = -1; m_busy_from = -1; m_prev_sat = 1'b0; m_new_sat = 1'b0;
        for (int a = 0; a < 3; a++) begin m_prev[a] = '0; m_new[a] = '0; end
        last_ov = 1'b0;
        #1;
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_grad",      64'({gx, gy}),  64'(0));
        chk("rst_grad_z",    64'(gz),        64'(0));
        chk("rst_sat",       64'(sat_flag),  64'(0));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (L + 2) tick();
    endtask

    task automatic issue(input logic [31:0] a, input logic [DW-1:0] k0,
                         input logic [DW-1:0] k1, input logic [DW-1:0] k2);
        in_valid = 1'b1; alpha = a;
        ksx[cyc + L] = k0; ksy[cyc + L] = k1; ksz[cyc + L] = k2;
    endtask

    task automatic run_job(input int n, input int hold, input bit noise);
        longint      acc [3];
        logic [DW:0] r;
        int          s;
        int          g;
        int          bound;
        for (int a = 0; a < 3; a++) acc[a] = 0;
        s = cyc;
        start = 1'b1; num_pts = CW'(n); in_valid = 1'b0;
        m_busy_from = s + 1; m_ov_at = 1 << 30;
        g_last_issue = s;
        for (int i = 0; i < n; i++) begin
            g = noise ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                step(noise);
            end
            issue(job_alpha[i], job_k[i][0], job_k[i][1], job_k[i][2]);
            for (int a = 0; a < 3; a++) acc[a] += term(job_alpha[i], job_k[i][a]);
            g_last_issue = cyc;
            step(noise);
        end
        in_valid = 1'b0;
        m_new_sat = 1'b0;
        for (int a = 0; a < 3; a++) begin
            r = model_out(acc[a]);
            m_new[a] = r[DW-1:0];
            m_new_sat = m_new_sat | r[DW];
        end
        m_ov_at = (n == 0) ? s + 2 : g_last_issue + L + 2;
        // Extra issues land after the counted ones and must be ignored
        if (noise) begin
            g = int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
                issue(pick(), pick(), pick(), pick());
                step(noise);
            end
            in_valid = 1'b0;
        end
        while (cyc < m_ov_at) step(noise);
        start = 1'b0; out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            start = noise && ($urandom_range(0, 1) == 1);
        end
        start = 1'b0; out_ready = 1'b1;
        bound = 0;
        while (m_ov_at >= 0 && bound < 8) begin
            tick();
            bound++;
        end
        out_ready = 1'b0;
        if (m_ov_at >= 0) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: result not accepted by cycle %0d (due at %0d)", cyc, m_ov_at);
            do_reset();
        end
    endtask

    initial begin
        int s;
        #1;
        do_reset();

        // 1: four points of 1.0 * 2.0
        for (int i = 0; i < 4; i++) begin
            job_alpha[i] = 32'h0001_0000;
            job_k[i][0] = 32'h0002_0000; job_k[i][1] = '0; job_k[i][2] = '0;
        end
        run_job(4, 0, 1'b0);
        chk("t1_grad_x",  64'(gx), 64'(32'h0008_0000));
        chk("t1_grad_yz", 64'({gy, gz}), 64'(0));
        chk("t1_latency", 64'(ov_seen - (g_last_issue + L)), 64'(2));
        drain();

        // 2: -0.5 * 3.0 twice
        for (int i = 0; i < 2; i++) begin
            job_alpha[i] = 32'hFFFF_8000;
            job_k[i][0] = '0; job_k[i][1] = 32'h0003_0000; job_k[i][2] = '0;
        end
        run_job(2, 2, 1'b0);
        chk("t2_grad_y",  64'(gy), 64'(32'hFFFD_0000));
        chk("t2_grad_xz", 64'({gx, gz}), 64'(0));
        drain();

        // 3: empty job, result held 5 cycles with start pulses
        run_job(0, 5, 1'b1);
        chk("t3_grad", 64'({gx, gy}), 64'(0));
        chk("t3_grad_z", 64'(gz), 64'(0));
        drain();

        // 4: reset with a partial sum in flight, then a clean one-point job
        s = cyc;
        start = 1'b1; num_pts = CW'(3);
        m_busy_from = s + 1; m_ov_at = 1 << 30;
        for (int i = 0; i < 3; i++) begin
            issue(32'h0001_0000, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        while (cyc < s + L + 1) tick();
        do_reset();
        drain();
        job_alpha[0] = 32'h0001_0000;
        for (int a = 0; a < 3; a++) job_k[0][a] = 32'h0001_0000;
        run_job(1, 1, 1'b0);
        chk("t4_grad_x", 64'(gx), 64'(32'h0001_0000));
        chk("t4_grad_y", 64'(gy), 64'(32'h0001_0000));
        chk("t4_grad_z", 64'(gz), 64'(32'h0001_0000));
        drain();

        // 5: z-axis overflow of the output width
        for (int i = 0; i < 3; i++) begin
            job_alpha[i] = 32'h0001_0000;
            job_k[i][0] = '0; job_k[i][1] = '0; job_k[i][2] = 32'h7FFF_0000;
        end
        run_job(3, 0, 1'b0);
`ifdef K_ZG_SAT_EN
        chk("t5_grad_z", 64'(gz), 64'(32'h7FFF_FFFF));
        chk("t5_sat",    64'(sat_flag), 64'(1));
`else
        chk("t5_grad_z", 64'(gz), 64'(32'h7FFD_0000));
        chk("t5_sat",    64'(sat_flag), 64'(0));
`endif
        drain();

        // 6: points issued with no job running
        for (int i = 0; i < 3; i++) begin
            issue(pick(), pick(), pick(), pick());
            tick();
        end
        in_valid = 1'b0;
        repeat (L + 3) tick();
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_out_valid", 64'(out_valid), 64'(0));

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            int n;
            n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                job_alpha[i] = pick();
                for (int a = 0; a < 3; a++) job_k[i][a] = pick();
            end
            run_job(n, int'($urandom_range(0, 3)), 1'b1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
